// File: rtl/puf_scan_auth_controller.sv
// Sequencer for the PUF scan-enable counter: fetches a PUF response, derives the
// shift/capture window lengths, and holds counter_start until the window plus guard is covered.
module puf_scan_auth_controller #(
  parameter int unsigned N_AUTH_MIN  = 16,
  parameter int unsigned L_SCAN_MIN  = 8,
  parameter int unsigned GUARD       = 2,
  parameter int unsigned PUF_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        auth_req,
  input  logic        abort,
  output logic        puf_req,
  input  logic        puf_valid,
  input  logic [31:0] puf_response,
  output logic [15:0] n_auth,
  output logic [15:0] l_scan,
  output logic        counter_start,
  input  logic [15:0] current_count,
  output logic        auth_busy,
  output logic        auth_done,
  output logic        auth_error
);

  localparam int unsigned CW = 16;
  localparam int unsigned FW = 10;
  localparam int unsigned TW = $clog2(PUF_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0]      state, state_nxt;
  logic [TW-1:0]   tmo, tmo_nxt;
  logic [2*FW-1:0] resp, resp_nxt;
  logic [CW-1:0]   end_count, end_count_nxt;
  logic [CW-1:0]   n_auth_nxt, l_scan_nxt;
  logic [CW-1:0]   n_new, l_new;
  logic            puf_req_nxt, counter_start_nxt, auth_busy_nxt, auth_done_nxt, auth_error_nxt;

  // Only the two 10-bit offset fields of the response are meaningful.
  logic unused_resp_bits;
  assign unused_resp_bits = ^{puf_response[31:26], puf_response[15:10]};

  // State and all output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      tmo           <= '0;
      resp          <= '0;
      end_count     <= '0;
      n_auth        <= '0;
      l_scan        <= '0;
      puf_req       <= 1'b0;
      counter_start <= 1'b0;
      auth_busy     <= 1'b0;
      auth_done     <= 1'b0;
      auth_error    <= 1'b0;
    end else begin
      state         <= state_nxt;
      tmo           <= tmo_nxt;
      resp          <= resp_nxt;
      end_count     <= end_count_nxt;
      n_auth        <= n_auth_nxt;
      l_scan        <= l_scan_nxt;
      puf_req       <= puf_req_nxt;
      counter_start <= counter_start_nxt;
      auth_busy     <= auth_busy_nxt;
      auth_done     <= auth_done_nxt;
      auth_error    <= auth_error_nxt;
    end
  end

  assign n_new = CW'(N_AUTH_MIN) + CW'(resp[FW-1:0]);
  assign l_new = CW'(L_SCAN_MIN) + CW'(resp[2*FW-1:FW]);

  // Next-state and next-output logic; abort pre-empts every other transition.
  always_comb begin
    state_nxt         = state;
    tmo_nxt           = tmo;
    resp_nxt          = resp;
    end_count_nxt     = end_count;
    n_auth_nxt        = n_auth;
    l_scan_nxt        = l_scan;
    puf_req_nxt       = puf_req;
    counter_start_nxt = counter_start;
    auth_done_nxt     = auth_done;
    auth_error_nxt    = auth_error;

    if (abort) begin
      state_nxt         = S_IDLE;
      puf_req_nxt       = 1'b0;
      counter_start_nxt = 1'b0;
      auth_done_nxt     = 1'b0;
      auth_error_nxt    = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (auth_req) begin
            state_nxt   = S_FETCH;
            puf_req_nxt = 1'b1;
            tmo_nxt     = '0;
          end
        end
        S_FETCH: begin
          if (puf_valid) begin
            resp_nxt    = {puf_response[25:16], puf_response[9:0]};
            puf_req_nxt = 1'b0;
            state_nxt   = S_LOAD;
          end else if (tmo == TW'(PUF_TIMEOUT - 1)) begin
            puf_req_nxt    = 1'b0;
            auth_error_nxt = 1'b1;
            state_nxt      = S_ERROR;
          end else begin
            tmo_nxt = tmo + TW'(1);
          end
        end
        S_LOAD: begin
          n_auth_nxt        = n_new;
          l_scan_nxt        = l_new;
          end_count_nxt     = n_new + l_new + CW'(GUARD);
          counter_start_nxt = 1'b1;
          state_nxt         = S_RUN;
        end
        S_RUN: begin
          // current_count lags by a cycle and reads 0 early on, so >= needs no special case.
          if (current_count >= end_count) begin
            counter_start_nxt = 1'b0;
            auth_done_nxt     = 1'b1;
            state_nxt         = S_DONE;
          end
        end
        S_DONE, S_ERROR: begin
          if (!auth_req) begin
            auth_done_nxt  = 1'b0;
            auth_error_nxt = 1'b0;
            state_nxt      = S_IDLE;
          end
        end
        default: begin
          state_nxt         = S_IDLE;
          puf_req_nxt       = 1'b0;
          counter_start_nxt = 1'b0;
          auth_done_nxt     = 1'b0;
          auth_error_nxt    = 1'b0;
        end
      endcase
    end

    auth_busy_nxt = (state_nxt == S_FETCH) || (state_nxt == S_LOAD) || (state_nxt == S_RUN);
  end

endmodule

// File: tb/tb_puf_scan_auth_controller.sv
// Self-checking bench for puf_scan_auth_controller with a free-running counter stand-in
// and a transaction-level model of window lengths and handshake durations.
module tb_puf_scan_auth_controller;

  logic        clk;
  logic        rst_n;
  logic        auth_req;
  logic        abort;
  logic        puf_req;
  logic        puf_valid;
  logic [31:0] puf_response;
  logic [15:0] n_auth;
  logic [15:0] l_scan;
  logic        counter_start;
  logic [15:0] current_count;
  logic        auth_busy;
  logic        auth_done;
  logic        auth_error;

  int checks = 0;
  int errors = 0;
  int held_n = 0;
  int held_l = 0;

  puf_scan_auth_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .auth_req      (auth_req),
    .abort         (abort),
    .puf_req       (puf_req),
    .puf_valid     (puf_valid),
    .puf_response  (puf_response),
    .n_auth        (n_auth),
    .l_scan        (l_scan),
    .counter_start (counter_start),
    .current_count (current_count),
    .auth_busy     (auth_busy),
    .auth_done     (auth_done),
    .auth_error    (auth_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in scan counter: counts while enabled, registered, clears when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) current_count <= 16'd0;
    else if (counter_start) current_count <= current_count + 16'd1;
    else current_count <= 16'd0;
  end

  typedef struct {
    logic [31:0] resp;
    int          delay;
    int          exp_n;
    int          exp_l;
    int          exp_end;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_n(input logic [31:0] r);
    return 16 + int'({22'd0, r[9:0]});
  endfunction

  function automatic int model_l(input logic [31:0] r);
    return 8 + int'({22'd0, r[25:16]});
  endfunction

  // One full request: PUF answers after `delay` cycles of puf_req (>=64 means never).
  task automatic do_auth(input logic [31:0] resp, input int delay,
                         input int en, input int el, input int ee);
    int   req_cyc = 0, cs_cyc = 0, cyc = 0, fall_at = -1, rise_at = -1;
    logic prev_req = 1'b0, prev_cs = 1'b0;
    auth_req = 1'b1;
    while (cyc < 5000 && !auth_done && !auth_error) begin
      tick();
      cyc++;
      if (prev_req && !puf_req) fall_at = cyc;
      if (!prev_cs && counter_start) rise_at = cyc;
      prev_req = puf_req;
      prev_cs  = counter_start;
      puf_valid    = 1'b0;
      puf_response = $urandom;
      if (puf_req) begin
        if (req_cyc == delay) begin
          puf_valid    = 1'b1;
          puf_response = resp;
        end
        req_cyc++;
      end
      if (counter_start) cs_cyc++;
    end
    puf_valid = 1'b0;
    chk("finished", int'(auth_done | auth_error), 1);
    chk("busy_at_end", int'(auth_busy), 0);
    if (delay < 64) begin
      chk("puf_req_cycles", req_cyc, delay + 1);
      chk("auth_done", int'(auth_done), 1);
      chk("auth_error", int'(auth_error), 0);
      chk("n_auth", int'(n_auth), en);
      chk("l_scan", int'(l_scan), el);
      chk("start_cycles", cs_cyc, ee + 1);
      chk("start_after_load", rise_at - fall_at, 1);
      held_n = en;
      held_l = el;
    end else begin
      chk("timeout_puf_req_cycles", req_cyc, 64);
      chk("timeout_error", int'(auth_error), 1);
      chk("timeout_no_start", cs_cyc, 0);
      chk("timeout_n_held", int'(n_auth), held_n);
      chk("timeout_l_held", int'(l_scan), held_l);
    end
    tick();
    tick();
    chk("flag_held", int'(auth_done | auth_error), 1);
    auth_req = 1'b0;
    tick();
    chk("done_cleared", int'(auth_done), 0);
    chk("error_cleared", int'(auth_error), 0);
    tick();
    chk("idle_no_req", int'(puf_req | auth_busy), 0);
  endtask

  task automatic wait_puf_req();
    int i = 0;
    while (i < 20 && !puf_req) begin
      tick();
      i++;
    end
    chk("puf_req_seen", int'(puf_req), 1);
  endtask

  initial begin
    vec_t vecs[5];
    logic [31:0] r;
    int d;

    vecs[0] = '{32'h0004_0005, 3, 21, 12, 35};
    vecs[1] = '{32'h03FF_03FF, 0, 1039, 1031, 2072};
    vecs[2] = '{32'hFC00_FC00, 5, 16, 8, 26};
    vecs[3] = '{32'h1234_5678, 63, 648, 572, 1222};
    vecs[4] = '{32'hDEAD_BEEF, 1000, 0, 0, 0};

    rst_n = 1'b0; auth_req = 1'b0; abort = 1'b0; puf_valid = 1'b0; puf_response = '0;
    #1;
    chk("rst_outputs", int'({puf_req, counter_start, auth_busy, auth_done, auth_error}), 0);
    chk("rst_n_auth", int'(n_auth), 0);
    chk("rst_l_scan", int'(l_scan), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_after_rst", int'(puf_req | auth_busy), 0);

    for (int i = 0; i < 5; i++)
      do_auth(vecs[i].resp, vecs[i].delay, vecs[i].exp_n, vecs[i].exp_l, vecs[i].exp_end);

    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      d = int'($urandom_range(0, 70));
      do_auth(r, d, model_n(r), model_l(r), model_n(r) + model_l(r) + 2);
    end

    // Abort while the counter reads 10 during RUN.
    auth_req = 1'b1;
    wait_puf_req();
    puf_valid = 1'b1;
    puf_response = 32'h0001_0002;
    tick();
    puf_valid = 1'b0;
    for (int i = 0; i < 50 && current_count != 16'd10; i++) tick();
    chk("abort_run_count", int'(current_count), 10);
    chk("abort_run_start_pre", int'(counter_start), 1);
    abort = 1'b1;
    auth_req = 1'b0;
    tick();
    abort = 1'b0;
    chk("abort_run_start", int'(counter_start), 0);
    chk("abort_run_busy", int'(auth_busy), 0);
    chk("abort_run_done", int'(auth_done), 0);
    chk("abort_run_n", int'(n_auth), 18);
    chk("abort_run_l", int'(l_scan), 9);
    tick();
    chk("abort_run_idle", int'(puf_req | auth_busy | counter_start), 0);

    // Abort coinciding with puf_valid: response must be discarded.
    auth_req = 1'b1;
    wait_puf_req();
    puf_valid = 1'b1;
    puf_response = 32'hFFFF_FFFF;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    puf_valid = 1'b0;
    auth_req = 1'b0;
    chk("abort_valid_req", int'(puf_req), 0);
    chk("abort_valid_busy", int'(auth_busy), 0);
    tick();
    tick();
    chk("abort_valid_idle", int'(auth_busy | counter_start), 0);
    chk("abort_valid_n", int'(n_auth), 18);
    chk("abort_valid_l", int'(l_scan), 9);
    held_n = 18;
    held_l = 9;

    // Asynchronous reset in the middle of RUN.
    auth_req = 1'b1;
    wait_puf_req();
    puf_valid = 1'b1;
    puf_response = 32'h0004_0005;
    tick();
    puf_valid = 1'b0;
    for (int i = 0; i < 50 && current_count != 16'd5; i++) tick();
    chk("rst_mid_start_pre", int'(counter_start), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_flags", int'({puf_req, counter_start, auth_busy, auth_done, auth_error}), 0);
    chk("rst_mid_n", int'(n_auth), 0);
    chk("rst_mid_l", int'(l_scan), 0);
    auth_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("rst_mid_idle", int'(puf_req | auth_busy | counter_start), 0);
    held_n = 0;
    held_l = 0;
    do_auth(vecs[0].resp, vecs[0].delay, vecs[0].exp_n, vecs[0].exp_l, vecs[0].exp_end);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
